alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_iter.sv | 76 +++++++
 rtl/alu_seq.sv | 143 ++++++++++++++
 tb/tb_alu_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared command codes, FSM state type and error-bit indices for alu_seq.
package alu_pkg;

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_SUB = 4'd1;
  localparam logic [3:0] CMD_MUL = 4'd2;
  localparam logic [3:0] CMD_DIV = 4'd3;
  localparam logic [3:0] CMD_MOD = 4'd4;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  localparam int unsigned ERR_OVF  = 0;
  localparam int unsigned ERR_DIVZ = 1;

  // True when the command needs the iterative engine; div/mod by zero short-circuits.
  function automatic logic needs_iter(input logic [3:0] cmd, input logic b_zero);
    return (cmd == CMD_MUL) || (((cmd == CMD_DIV) || (cmd == CMD_MOD)) && !b_zero);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Radix-2 iterative engine: shift-add multiply and restoring divide on one shared
// double-width shift register. Outputs reflect the value after the current step so
// the parent can capture them on the edge where done is high.
module alu_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op,         // 0 multiply, 1 divide
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [RW-1:0]    sh_q, sh_d;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             op_q;

  logic [WIDTH:0]   mul_hi;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  // One step of either algorithm, selected by the latched op.
  always_comb begin
    mul_hi = {1'b0, sh_q[RW-1:WIDTH]} + (sh_q[0] ? {1'b0, b_q} : '0);
    trial  = sh_q[RW-1:WIDTH-1];
    diff   = trial[WIDTH-1:0] - b_q;
    sh_d   = sh_q;
    if (!op_q) begin
      // Multiplier sits in the low half and is consumed LSB first as the sum shifts down.
      sh_d = {mul_hi, sh_q[WIDTH-1:1]};
    end else if (trial >= {1'b0, b_q}) begin
      sh_d = {diff, sh_q[WIDTH-2:0], 1'b1};
    end else begin
      sh_d = {trial[WIDTH-1:0], sh_q[WIDTH-2:0], 1'b0};
    end
  end

  assign done      = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product   = sh_d;
  assign quotient  = sh_d[WIDTH-1:0];
  assign remainder = sh_d[RW-1:WIDTH];

  // Load on start, then step once per cycle until WIDTH steps are done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      op_q   <= 1'b0;
    end else if (start) begin
      sh_q   <= {{WIDTH{1'b0}}, a};
      b_q    <= b;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      op_q   <= op;
    end else if (busy_q) begin
      sh_q  <= sh_d;
      cnt_q <= cnt_q + 1'b1;
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready on both sides. Add/sub and short-circuit cases
// finish in one cycle; mul/div/mod use alu_iter for WIDTH cycles.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned  WIDTH  = 16,
  localparam int unsigned RWIDTH = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [WIDTH-1:0]  inputA,
  input  logic [WIDTH-1:0]  inputB,
  input  logic [3:0]        command,
  output logic              outValid,
  input  logic              outReady,
  output logic [RWIDTH-1:0] result,
  output logic [1:0]        error
);

  state_e state_q, state_d;

  logic              accept;
  logic              out_xfer;
  logic              b_zero;
  logic              iter_start;
  logic              iter_op;
  logic [3:0]        cmd_q;

  logic              is_sub;
  logic [WIDTH-1:0]  bx;
  logic [WIDTH:0]    sum;
  logic [RWIDTH-1:0] fast_res;
  logic [1:0]        fast_err;

  logic              iter_done;
  logic [RWIDTH-1:0] iter_prod;
  logic [WIDTH-1:0]  iter_quo;
  logic [WIDTH-1:0]  iter_rem;

  logic [RWIDTH-1:0] result_q, result_d;
  logic [1:0]        error_q, error_d;

  assign inReady    = (state_q == IDLE) || ((state_q == DONE) && outReady);
  assign outValid   = (state_q == DONE);
  assign accept     = inValid && inReady;
  assign out_xfer   = outValid && outReady;
  assign b_zero     = (inputB == '0);
  assign iter_start = accept && needs_iter(command, b_zero);
  assign iter_op    = (command != CMD_MUL);
  assign result     = result_q;
  assign error      = error_q;

  alu_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (iter_start),
    .op       (iter_op),
    .a        (inputA),
    .b        (inputB),
    .done     (iter_done),
    .product  (iter_prod),
    .quotient (iter_quo),
    .remainder(iter_rem)
  );

  // Single-cycle results computed straight from the inputs being accepted.
  always_comb begin
    is_sub   = (command == CMD_SUB);
    bx       = inputB ^ {WIDTH{is_sub}};
    sum      = {1'b0, inputA} + {1'b0, bx} + {{WIDTH{1'b0}}, is_sub};
    fast_res = '0;
    fast_err = 2'b00;
    unique case (command)
      CMD_ADD, CMD_SUB: begin
        fast_res = {{(RWIDTH - WIDTH - 1){1'b0}}, sum};
        // Carry into the MSB is recovered from the MSB sum bit and its two inputs.
        fast_err[ERR_OVF] = (sum[WIDTH-1] ^ inputA[WIDTH-1] ^ bx[WIDTH-1]) ^ sum[WIDTH];
      end
      CMD_DIV, CMD_MOD: fast_err[ERR_DIVZ] = b_zero;
      default: ;
    endcase
  end

  // Next state and result/error update; result only changes on entry to DONE.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    error_d  = error_q;
    if (accept) begin
      if (iter_start) begin
        state_d = EXEC;
      end else begin
        state_d  = DONE;
        result_d = fast_res;
        error_d  = fast_err;
      end
    end else begin
      unique case (state_q)
        EXEC: begin
          if (iter_done) begin
            state_d = DONE;
            error_d = 2'b00;
            if (cmd_q == CMD_MUL) begin
              result_d = iter_prod;
            end else if (cmd_q == CMD_DIV) begin
              result_d = {{WIDTH{1'b0}}, iter_quo};
            end else begin
              result_d = {{WIDTH{1'b0}}, iter_rem};
            end
          end
        end
        DONE: begin
          if (out_xfer) begin
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // State, captured command and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= 4'd0;
      result_q <= '0;
      error_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      error_q  <= error_d;
      if (accept) begin
        cmd_q <= command;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16): the driver pushes expected responses,
// a monitor pops and compares on every output transfer.
module tb_alu_seq;

  localparam int unsigned W  = 16;
  localparam int unsigned RW = 32;

  logic          clk;
  logic          rst_n;
  logic          inValid;
  logic          inReady;
  logic [W-1:0]  inputA;
  logic [W-1:0]  inputB;
  logic [3:0]    command;
  logic          outValid;
  logic          outReady;
  logic [RW-1:0] result;
  logic [1:0]    error;

  typedef struct {
    logic [RW-1:0] res;
    logic [1:0]    err;
    int            lat;   // 0 = latency not checked
    int            k;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  alu_seq #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inValid (inValid),
    .inReady (inReady),
    .inputA  (inputA),
    .inputB  (inputB),
    .command (command),
    .outValid(outValid),
    .outReady(outReady),
    .result  (result),
    .error   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && outValid && outReady) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got result=%0h error=%b, required no output",
                 result, error);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res || error !== e.err ||
            (e.lat != 0 && (cyc - e.k) != e.lat)) begin
          errors++;
          $display("FAIL %s: got result=%0h error=%b latency=%0d, required result=%0h error=%b latency=%0d",
                   e.name, result, error, cyc - e.k, e.res, e.err, e.lat);
        end
      end
    end
  end

  task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Present one op and wait (bounded) for acceptance; returns the accept cycle.
  task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] cmd, input logic [RW-1:0] res, input logic [1:0] err,
                       input int lat, input bit expect_out, output int k);
    int n;
    exp_t e;
    @(negedge clk);
    inValid = 1'b1;
    inputA  = a;
    inputB  = b;
    command = cmd;
    n = 0;
    while (!inReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    k = cyc;
    if (!inReady) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: got inReady=0, required 1 within 100 cycles", name);
    end else if (expect_out) begin
      e.res  = res;
      e.err  = err;
      e.lat  = lat;
      e.k    = k;
      e.name = name;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inputA  = '1;   // scribble operands to show they were captured on accept
    inputB  = '1;
    command = 4'hF;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: got %0d pending, required 0", name, sb.size());
      sb.delete();
    end
    #1;
  endtask

  initial begin
    int k, k1, k2, k3, seen;
    rst_n    = 1'b0;
    inValid  = 1'b0;
    inputA   = '0;
    inputB   = '0;
    command  = 4'd0;
    outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_inReady", 32'(inReady), 32'd1);
    check("reset_outValid", 32'(outValid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_error", 32'(error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("add_1000_2049", 16'd1000, 16'd2049, 4'd0, 32'd3049, 2'b00, 1, 1'b1, k);
    issue("sub_1000_2049", 16'd1000, 16'd2049, 4'd1, 32'd64487, 2'b00, 1, 1'b1, k);
    issue("add_ovf", 16'h7FFF, 16'd1, 4'd0, 32'd32768, 2'b01, 1, 1'b1, k);
    issue("sub_ovf", 16'h8000, 16'd1, 4'd1, 32'h17FFF, 2'b01, 1, 1'b1, k);
    issue("mul_1000_2049", 16'd1000, 16'd2049, 4'd2, 32'd2049000, 2'b00, 17, 1'b1, k);
    issue("mul_max", 16'hFFFF, 16'hFFFF, 4'd2, 32'hFFFE0001, 2'b00, 17, 1'b1, k);
    issue("div_50000_7", 16'd50000, 16'd7, 4'd3, 32'd7142, 2'b00, 17, 1'b1, k);
    issue("mod_50000_7", 16'd50000, 16'd7, 4'd4, 32'd6, 2'b00, 17, 1'b1, k);
    issue("div_small", 16'd5, 16'd9, 4'd3, 32'd0, 2'b00, 17, 1'b1, k);
    issue("div_by_zero", 16'd5, 16'd0, 4'd3, 32'd0, 2'b10, 1, 1'b1, k);
    issue("mod_by_zero", 16'd5, 16'd0, 4'd4, 32'd0, 2'b10, 1, 1'b1, k);
    issue("reserved_9", 16'd123, 16'd45, 4'd9, 32'd0, 2'b00, 1, 1'b1, k);
    drain("directed");

    // Backpressure: result must hold and inReady stay low while outReady is low.
    outReady = 1'b0;
    issue("add_held", 16'd300, 16'd45, 4'd0, 32'd345, 2'b00, 0, 1'b1, k);
    repeat (5) begin
      @(negedge clk);
      check("hold_outValid", 32'(outValid), 32'd1);
      check("hold_inReady", 32'(inReady), 32'd0);
      check("hold_result", result, 32'd345);
    end
    @(posedge clk);
    #1;
    outReady = 1'b1;
    drain("held");

    // Back-to-back single-cycle ops: accepts on consecutive cycles.
    issue("b2b_0", 16'd1, 16'd2, 4'd0, 32'd3, 2'b00, 1, 1'b1, k1);
    issue("b2b_1", 16'd10, 16'd20, 4'd0, 32'd30, 2'b00, 1, 1'b1, k2);
    issue("b2b_2", 16'hFFFF, 16'd1, 4'd0, 32'h10000, 2'b00, 1, 1'b1, k3);
    check("b2b_gap_1", 32'(k2 - k1), 32'd1);
    check("b2b_gap_2", 32'(k3 - k2), 32'd1);
    drain("b2b");

    // Reset 5 cycles into a multiply: no output for it, and the unit recovers.
    issue("mul_aborted", 16'd1000, 16'd2049, 4'd2, 32'd0, 2'b00, 0, 1'b0, k);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outValid", 32'(outValid), 32'd0);
    check("abort_inReady", 32'(inReady), 32'd1);
    check("abort_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (outValid) seen++;
    end
    check("abort_no_outValid", 32'(seen), 32'd0);
    issue("add_after_reset", 16'd7, 16'd8, 4'd0, 32'd15, 2'b00, 1, 1'b1, k);
    drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1);
  end

endmodule
